// File: rtl/myproject_pkg.sv
// Shared definitions for the myproject MAC datapath: width derivation helpers
// and the legal multiplier pipeline depth range.
package myproject_pkg;

  localparam int MUL_STAGE_MIN = 1;
  localparam int MUL_STAGE_MAX = 4;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int n);
    int r;
    int p;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      p = 1 << i;
      if (p < n) r = i + 1;
    end
    return r;
  endfunction

  // Full-precision signed product width.
  function automatic int prod_width(input int w0, input int w1);
    return w0 + w1;
  endfunction

  // Accumulator width that cannot overflow when summing len full products.
  function automatic int acc_width(input int w0, input int w1, input int len);
    return prod_width(w0, w1) + clog2(len);
  endfunction

  // Element counter width, at least one bit even for single-element vectors.
  function automatic int cnt_width(input int len);
    return (clog2(len) > 0) ? clog2(len) : 1;
  endfunction

endpackage

// File: rtl/myproject_mul_pipe.sv
// Enable-gated signed multiplier pipeline, NUM_STAGE registers deep.
// Each stage carries a valid bit; the whole pipe freezes when en is low.
module myproject_mul_pipe
  import myproject_pkg::*;
#(
  parameter int DIN0_WIDTH = 16,
  parameter int DIN1_WIDTH = 10,
  parameter int NUM_STAGE  = 2
) (
  input  logic                                                 ap_clk,
  input  logic                                                 ap_rst_n,
  input  logic                                                 en,
  input  logic                                                 in_valid,
  input  logic signed [DIN0_WIDTH-1:0]                         din0,
  input  logic signed [DIN1_WIDTH-1:0]                         din1,
  output logic                                                 prod_valid,
  output logic signed [prod_width(DIN0_WIDTH, DIN1_WIDTH)-1:0] prod
);

  localparam int PROD_W = prod_width(DIN0_WIDTH, DIN1_WIDTH);

  logic signed [PROD_W-1:0] prod_p [NUM_STAGE];
  logic                     vld_p  [NUM_STAGE];

  // Product data path: stage 0 multiplies, later stages shift forward.
  always_ff @(posedge ap_clk) begin
    if (en) begin
      prod_p[0] <= PROD_W'(din0) * PROD_W'(din1);
      for (int i = 1; i < NUM_STAGE; i++) begin
        prod_p[i] <= prod_p[i-1];
      end
    end
  end

  // Valid bits travel alongside the product; cleared by reset.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      for (int i = 0; i < NUM_STAGE; i++) begin
        vld_p[i] <= 1'b0;
      end
    end else if (en) begin
      vld_p[0] <= in_valid;
      for (int i = 1; i < NUM_STAGE; i++) begin
        vld_p[i] <= vld_p[i-1];
      end
    end
  end

  assign prod_valid = vld_p[NUM_STAGE-1];
  assign prod       = prod_p[NUM_STAGE-1];

endmodule

// File: rtl/myproject_mac_pipe.sv
// Pipelined signed multiply-accumulate producing one DOT_LEN-element dot
// product per result, with a valid/ready handshake on both sides.
// Build option: define MYPROJECT_MAC_SAT_EN to saturate the result to the
// DOUT_WIDTH range (dout_ovf flags a clamp); otherwise the result wraps.
module myproject_mac_pipe
  import myproject_pkg::*;
#(
  parameter int ID         = 1,
  parameter int DIN0_WIDTH = 16,
  parameter int DIN1_WIDTH = 10,
  parameter int DOUT_WIDTH = 26,
  parameter int NUM_STAGE  = 2,
  parameter int DOT_LEN    = 8
) (
  input  logic                         ap_clk,
  input  logic                         ap_rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DIN0_WIDTH-1:0] din0,
  input  logic signed [DIN1_WIDTH-1:0] din1,
  output logic                         dout_valid,
  input  logic                         dout_ready,
  output logic signed [DOUT_WIDTH-1:0] dout,
  output logic                         dout_ovf
);

  localparam int PROD_W = prod_width(DIN0_WIDTH, DIN1_WIDTH);
  localparam int ACC_W  = acc_width(DIN0_WIDTH, DIN1_WIDTH, DOT_LEN);
  localparam int CNT_W  = cnt_width(DOT_LEN);
  localparam int FIT_W  = (ACC_W > DOUT_WIDTH) ? ACC_W : DOUT_WIDTH;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DOT_LEN - 1);

  if (ID < 0 || NUM_STAGE < MUL_STAGE_MIN || NUM_STAGE > MUL_STAGE_MAX || DOT_LEN < 1) begin : g_bad_param
    $error("myproject_mac_pipe: illegal parameter set");
  end

  logic                    en;
  logic                    vld_p0;
  logic signed [PROD_W-1:0] prod_p0;
  logic signed [ACC_W-1:0]  prod_ext_p0;
  logic [CNT_W-1:0]         cnt;
  logic signed [ACC_W-1:0]  acc_p1;
  logic                     vld_p1;

  // A pending result that is not being taken freezes the whole datapath.
  assign en       = !(dout_valid && !dout_ready);
  assign in_ready = en;

  myproject_mul_pipe #(
    .DIN0_WIDTH (DIN0_WIDTH),
    .DIN1_WIDTH (DIN1_WIDTH),
    .NUM_STAGE  (NUM_STAGE)
  ) u_mul (
    .ap_clk     (ap_clk),
    .ap_rst_n   (ap_rst_n),
    .en         (en),
    .in_valid   (in_valid),
    .din0       (din0),
    .din1       (din1),
    .prod_valid (vld_p0),
    .prod       (prod_p0)
  );

  assign prod_ext_p0 = ACC_W'(prod_p0);

  // ---- stage p1: accumulate; vld_p1 marks a completed dot product ----
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      cnt    <= '0;
      acc_p1 <= '0;
      vld_p1 <= 1'b0;
    end else if (en) begin
      vld_p1 <= vld_p0 && (cnt == CNT_LAST);
      if (vld_p0) begin
        acc_p1 <= (cnt == '0) ? prod_ext_p0 : acc_p1 + prod_ext_p0;
        cnt    <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
      end
    end
  end

  // ---- stage p2: output register ----
`ifdef MYPROJECT_MAC_SAT_EN
  // Clamp to the signed DOUT_WIDTH range; returns {clamped, value}.
  function automatic logic [DOUT_WIDTH:0] sat_fit(input logic signed [ACC_W-1:0] a);
    logic signed [FIT_W-1:0] ax;
    logic signed [FIT_W-1:0] hi;
    logic signed [FIT_W-1:0] lo;
    ax = FIT_W'(a);
    hi = FIT_W'({1'b0, {(DOUT_WIDTH-1){1'b1}}});
    lo = FIT_W'($signed({1'b1, {(DOUT_WIDTH-1){1'b0}}}));
    if (ax > hi)      sat_fit = {1'b1, hi[DOUT_WIDTH-1:0]};
    else if (ax < lo) sat_fit = {1'b1, lo[DOUT_WIDTH-1:0]};
    else              sat_fit = {1'b0, ax[DOUT_WIDTH-1:0]};
  endfunction

  logic [DOUT_WIDTH:0] fit_p1;
  assign fit_p1 = sat_fit(acc_p1);

  // Load the clamped result; valid clears on handshake unless a new one loads.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      dout_valid <= 1'b0;
      dout       <= '0;
      dout_ovf   <= 1'b0;
    end else if (en) begin
      dout_valid <= vld_p1;
      if (vld_p1) begin
        dout     <= fit_p1[DOUT_WIDTH-1:0];
        dout_ovf <= fit_p1[DOUT_WIDTH];
      end
    end
  end
`else
  // Keep the low DOUT_WIDTH bits (sign-extend if the accumulator is narrower).
  function automatic logic signed [DOUT_WIDTH-1:0] wrap_fit(input logic signed [ACC_W-1:0] a);
    logic signed [FIT_W-1:0] ax;
    ax = FIT_W'(a);
    wrap_fit = ax[DOUT_WIDTH-1:0];
  endfunction

  assign dout_ovf = 1'b0;

  // Load the wrapped result; valid clears on handshake unless a new one loads.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      dout_valid <= 1'b0;
      dout       <= '0;
    end else if (en) begin
      dout_valid <= vld_p1;
      if (vld_p1) begin
        dout <= wrap_fit(acc_p1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_myproject_mac_pipe.sv
// Directed bench for myproject_mac_pipe: three instances cover DOT_LEN=4,
// DOT_LEN=8 (overflow/saturation) and DOT_LEN=1 with a 4-deep multiplier.
module tb_myproject_mac_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   last_acc = 0;
  int   a_nr_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  logic               a_in_valid, a_in_ready, a_dout_valid, a_dout_ready, a_dout_ovf;
  logic signed [15:0] a_din0;
  logic signed [9:0]  a_din1;
  logic signed [25:0] a_dout;
  logic               b_in_valid, b_in_ready, b_dout_valid, b_dout_ready, b_dout_ovf;
  logic signed [15:0] b_din0;
  logic signed [9:0]  b_din1;
  logic signed [25:0] b_dout;
  logic               c_in_valid, c_in_ready, c_dout_valid, c_dout_ready, c_dout_ovf;
  logic signed [15:0] c_din0;
  logic signed [9:0]  c_din1;
  logic signed [25:0] c_dout;

  myproject_mac_pipe #(.ID(1), .DIN0_WIDTH(16), .DIN1_WIDTH(10), .DOUT_WIDTH(26),
                       .NUM_STAGE(2), .DOT_LEN(4)) dut_a (
    .ap_clk(clk), .ap_rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .din0(a_din0), .din1(a_din1), .dout_valid(a_dout_valid), .dout_ready(a_dout_ready),
    .dout(a_dout), .dout_ovf(a_dout_ovf));

  myproject_mac_pipe #(.ID(2), .DIN0_WIDTH(16), .DIN1_WIDTH(10), .DOUT_WIDTH(26),
                       .NUM_STAGE(2), .DOT_LEN(8)) dut_b (
    .ap_clk(clk), .ap_rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .din0(b_din0), .din1(b_din1), .dout_valid(b_dout_valid), .dout_ready(b_dout_ready),
    .dout(b_dout), .dout_ovf(b_dout_ovf));

  myproject_mac_pipe #(.ID(3), .DIN0_WIDTH(16), .DIN1_WIDTH(10), .DOUT_WIDTH(26),
                       .NUM_STAGE(4), .DOT_LEN(1)) dut_c (
    .ap_clk(clk), .ap_rst_n(rst_n), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .din0(c_din0), .din1(c_din1), .dout_valid(c_dout_valid), .dout_ready(c_dout_ready),
    .dout(c_dout), .dout_ovf(c_dout_ovf));

  typedef struct packed {
    logic signed [25:0] d;
    logic               o;
    int                 c;
  } res_t;

  res_t qa[$];
  res_t qb[$];
  res_t qc[$];

  // Result capture: a handshake seen here completes on the next rising edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (a_dout_valid && a_dout_ready) qa.push_back({a_dout, a_dout_ovf, cyc});
      if (b_dout_valid && b_dout_ready) qb.push_back({b_dout, b_dout_ovf, cyc});
      if (c_dout_valid && c_dout_ready) qc.push_back({c_dout, c_dout_ovf, cyc});
      if (a_dout_ready && !a_in_ready) a_nr_cnt <= a_nr_cnt + 1;
    end
  end

  typedef struct packed {
    logic [3:0][15:0]   a;
    logic [3:0][9:0]    b;
    logic signed [25:0] exp;
  } vec_t;

  vec_t vt [5];

  task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic drive(input int sel, input logic v, input logic signed [15:0] d0, input logic signed [9:0] d1);
    case (sel)
      0: begin a_in_valid = v; a_din0 = d0; a_din1 = d1; end
      1: begin b_in_valid = v; b_din0 = d0; b_din1 = d1; end
      default: begin c_in_valid = v; c_din0 = d0; c_din1 = d1; end
    endcase
  endtask

  // Present one pair and hold it until accepted (bounded).
  task automatic send(input int sel, input logic signed [15:0] d0, input logic signed [9:0] d1);
    bit ok;
    int n;
    ok = 1'b0;
    n  = 0;
    drive(sel, 1'b1, d0, d1);
    while (!ok && n < 100) begin
      @(negedge clk);
      ok = (sel == 0) ? a_in_ready : (sel == 1) ? b_in_ready : c_in_ready;
      if (ok) last_acc = cyc + 1;
      @(posedge clk); #1;
      n++;
    end
    drive(sel, 1'b0, d0, d1);
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL send%0d: pair not accepted within %0d cycles", sel, n);
    end
  endtask

  function automatic int qsize(input int sel);
    case (sel)
      0:       return qa.size();
      1:       return qb.size();
      default: return qc.size();
    endcase
  endfunction

  task automatic wait_q(input int sel, input int n);
    int t;
    t = 0;
    while (qsize(sel) < n && t < 300) begin
      @(posedge clk); #2;
      t++;
    end
    if (qsize(sel) < n) begin
      checks++;
      failures++;
      $display("FAIL wait_q%0d: got %0d results required %0d", sel, qsize(sel), n);
    end
  endtask

  task automatic pop(input int sel, output res_t r);
    r.d = 'x;
    r.o = 1'bx;
    r.c = -1000;
    case (sel)
      0:       if (qa.size() > 0) r = qa.pop_front();
      1:       if (qb.size() > 0) r = qb.pop_front();
      default: if (qc.size() > 0) r = qc.pop_front();
    endcase
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    res_t r;
    res_t r2;
    int   prev_c;
    logic signed [25:0] exp_b;
    logic               exp_bo;

    vt[0].a = {4{16'sd3}};                                   vt[0].b = {4{-10'sd2}};
    vt[0].exp = -26'sd24;
    vt[1].a = {16'sd0, -16'sd1, 16'sd2, 16'sd1};             vt[1].b = {10'sd7, 10'sd5, 10'sd2, 10'sd1};
    vt[1].exp = 26'sd0;
    vt[2].a = {-16'sd32768, 16'sd32767, -16'sd200, 16'sd100}; vt[2].b = {-10'sd512, 10'sd511, 10'sd7, -10'sd3};
    vt[2].exp = 26'sd33519453;
    vt[3].a = {16'sd0, 16'sd5, -16'sd1, -16'sd1};            vt[3].b = {10'sd0, -10'sd100, 10'sd1, -10'sd1};
    vt[3].exp = -26'sd500;
    vt[4].a = {-16'sd1, 16'sd1, 16'sd32767, 16'sd32767};     vt[4].b = {10'sd1, 10'sd1, -10'sd512, -10'sd512};
    vt[4].exp = -26'sd33553408;

    rst_n = 1'b0;
    drive(0, 1'b0, 16'sd0, 10'sd0);
    drive(1, 1'b0, 16'sd0, 10'sd0);
    drive(2, 1'b0, 16'sd0, 10'sd0);
    a_dout_ready = 1'b1;
    b_dout_ready = 1'b1;
    c_dout_ready = 1'b1;

    repeat (3) @(posedge clk);
    #2;
    check("rst_a_dout_valid", a_dout_valid, 0);
    check("rst_a_dout", a_dout, 0);
    check("rst_a_dout_ovf", a_dout_ovf, 0);
    check("rst_a_in_ready", a_in_ready, 1);
    check("rst_b_dout_valid", b_dout_valid, 0);
    check("rst_c_dout_valid", c_dout_valid, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Table of isolated vectors on the DOT_LEN=4 instance.
    for (int v = 0; v < 5; v++) begin
      for (int i = 0; i < 4; i++) send(0, $signed(vt[v].a[i]), $signed(vt[v].b[i]));
      wait_q(0, 1);
      pop(0, r);
      check($sformatf("vec%0d_dout", v), $signed(r.d), vt[v].exp);
      check($sformatf("vec%0d_ovf", v), r.o, 0);
      check($sformatf("vec%0d_latency", v), r.c - last_acc, 3);
      repeat (2) @(posedge clk);
      #1;
    end

    // Three vectors streamed back to back.
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < 4; i++) send(0, $signed(vt[1].a[i]), $signed(vt[1].b[i]));
    wait_q(0, 3);
    prev_c = 0;
    for (int k = 0; k < 3; k++) begin
      pop(0, r);
      check($sformatf("stream%0d_dout", k), $signed(r.d), 0);
      if (k > 0) check($sformatf("stream%0d_spacing", k), r.c - prev_c, 4);
      prev_c = r.c;
    end

    // Backpressure: hold dout_ready low for 5 cycles with a result pending.
    a_dout_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 4; i++) send(0, 16'sd2, 10'sd3);
        for (int i = 0; i < 4; i++) send(0, 16'sd1, -10'sd1);
      end
      begin
        int t;
        t = 0;
        while (!a_dout_valid && t < 100) begin
          @(posedge clk); #2;
          t++;
        end
        check("bp_pending_valid", a_dout_valid, 1);
        for (int i = 0; i < 5; i++) begin
          check($sformatf("bp_hold_dout_%0d", i), a_dout, 24);
          check($sformatf("bp_in_ready_%0d", i), a_in_ready, 0);
          check($sformatf("bp_valid_%0d", i), a_dout_valid, 1);
          @(posedge clk); #2;
        end
        a_dout_ready = 1'b1;
      end
    join
    wait_q(0, 2);
    pop(0, r);
    check("bp_first_dout", $signed(r.d), 24);
    pop(0, r);
    check("bp_second_dout", $signed(r.d), -4);
    @(posedge clk); #1;

    // Reset in the middle of a vector.
    send(0, 16'sd9, 10'sd9);
    send(0, 16'sd9, 10'sd9);
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #2;
      check($sformatf("midrst_valid_%0d", i), a_dout_valid, 0);
      check($sformatf("midrst_in_ready_%0d", i), a_in_ready, 1);
      check($sformatf("midrst_dout_%0d", i), a_dout, 0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("midrst_no_partial", qa.size(), 0);
    for (int i = 0; i < 4; i++) send(0, 16'sd5, 10'sd5);
    wait_q(0, 1);
    pop(0, r);
    check("midrst_new_dout", $signed(r.d), 100);
    repeat (4) @(posedge clk);
    #1;
    check("midrst_single_result", qa.size(), 0);

    // DOT_LEN=8 with the largest product eight times: 2^27.
`ifdef MYPROJECT_MAC_SAT_EN
    exp_b  = 26'sd33554431;
    exp_bo = 1'b1;
`else
    exp_b  = 26'sd0;
    exp_bo = 1'b0;
`endif
    for (int i = 0; i < 8; i++) send(1, -16'sd32768, -10'sd512);
    wait_q(1, 1);
    pop(1, r);
    check("ovf_dout", $signed(r.d), exp_b);
    check("ovf_flag", r.o, exp_bo);

    // DOT_LEN=1, NUM_STAGE=4: single-pair results.
    send(2, -16'sd7, 10'sd9);
    wait_q(2, 1);
    pop(2, r);
    check("len1_dout", $signed(r.d), -63);
    check("len1_latency", r.c - last_acc, 5);
    send(2, 16'sd4, -10'sd3);
    send(2, 16'sd6, 10'sd6);
    wait_q(2, 2);
    pop(2, r);
    pop(2, r2);
    check("len1_b2b_first", $signed(r.d), -12);
    check("len1_b2b_second", $signed(r2.d), 36);
    check("len1_b2b_spacing", r2.c - r.c, 1);

    check("a_in_ready_while_dout_ready", a_nr_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/myproject_mac_pipe.md
MYPROJECT_MAC_PIPE -- requirements
Module: myproject_mac_pipe

Interface
REQ-001 SHALL have parameter ID, default 1, instance identifier with no functional effect.
REQ-002 SHALL have parameter DIN0_WIDTH, default 16, signed width of operand 0.
REQ-003 SHALL have parameter DIN1_WIDTH, default 10, signed width of operand 1.
REQ-004 SHALL have parameter DOUT_WIDTH, default 26, signed result width.
REQ-005 SHALL have parameter NUM_STAGE, default 2, multiplier pipeline registers; legal range 1..4.
REQ-006 SHALL have parameter DOT_LEN, default 8, products summed per result; legal range >=1.
REQ-007 SHALL have ports ap_clk, input, 1, clock; all state updates on its rising edge.
REQ-008 SHALL have port ap_rst_n, input, 1, reset; asynchronous and active-low.
REQ-009 SHALL have ports in_valid (input, 1) and in_ready (output, 1): operand handshake.
REQ-010 SHALL have ports din0 (input, DIN0_WIDTH) and din1 (input, DIN1_WIDTH): signed operands.
REQ-011 SHALL have ports dout_valid (output, 1) and dout_ready (input, 1): result handshake.
REQ-012 SHALL have ports dout (output, DOUT_WIDTH), the signed dot product, and dout_ovf (output, 1), the overflow flag.

Function
REQ-013 SHALL accept an operand pair when in_valid && in_ready are both high on a rising edge.
REQ-014 SHALL define the advance enable as en = !(dout_valid && !dout_ready) and drive in_ready = en.
REQ-015 SHALL compute the full-precision signed product din0*din1 (DIN0_WIDTH+DIN1_WIDTH bits) through NUM_STAGE registers; each register advances only when en is high and carries a valid bit.
REQ-016 SHALL accumulate at ACC_WIDTH = DIN0_WIDTH+DIN1_WIDTH+clog2(DOT_LEN), with the product sign-extended and no internal overflow possible.
REQ-017 SHALL keep an element counter 0..DOT_LEN-1: a valid product at count 0 loads acc = product; otherwise acc = acc + product.
REQ-018 SHALL, on the valid product at count DOT_LEN-1, load the output register, set dout_valid, and wrap the count to 0.
REQ-019 SHALL drive dout_valid NUM_STAGE+1 cycles after acceptance of the final pair when dout_ready is held high.
REQ-020 SHALL support back-to-back vectors with no bubble; one pair per cycle is sustained while dout_ready is high.
REQ-021 SHALL clear dout_valid on handshake unless a new result loads in the same cycle; a simultaneous load takes priority.
REQ-022 SHALL hold dout, dout_ovf and all pipeline state stable while dout_valid && !dout_ready.
REQ-023 SHALL make DOT_LEN=1 produce one result per pair, with the counter permanently 0.

Reset
REQ-024 SHALL, while ap_rst_n is low, clear all pipeline valid bits, the counter, acc, dout, dout_ovf and dout_valid to 0; in_ready SHALL follow en and so read 1.
REQ-025 SHALL discard any partial vector on reset mid-operation; the next accepted pair starts a new vector.

Configuration
REQ-026 SHALL, with MYPROJECT_MAC_SAT_EN defined, clamp acc to the signed DOUT_WIDTH range when loading dout and set dout_ovf=1 when clamped, else 0.
REQ-027 SHALL, without MYPROJECT_MAC_SAT_EN, load dout with the low DOUT_WIDTH bits of acc (wrap) and tie dout_ovf to 0.

Structure
REQ-028 SHALL place clog2 and the ACC_WIDTH/product-width derivation functions in the shared package myproject_pkg.
REQ-029 SHALL isolate the NUM_STAGE-deep enable-gated product pipeline as sub-module myproject_mul_pipe.

Verification (DOT_LEN=4, NUM_STAGE=2, defaults otherwise unless stated)
REQ-030 SHALL check the basic dot product: 4 pairs (3,-2), dout_ready=1 -> dout=-24, dout_valid 3 cycles after the 4th accept, dout_ovf=0.
REQ-031 SHALL check streaming: 3 back-to-back vectors (1,1),(2,2),(-1,5),(0,7) repeated -> three results of 0, one per 4 cycles, in_ready constantly 1.
REQ-032 SHALL check backpressure: dout_ready=0 for 5 cycles while a result is pending -> dout stable, in_ready=0, no pair lost, next result correct.
REQ-033 SHALL check saturation with DOT_LEN=8 and 8 pairs (-32768,-512): with the macro -> dout=33554431, dout_ovf=1; without it -> dout=0 (2^27 wrapped), dout_ovf=0.
REQ-034 SHALL check reset mid-vector: ap_rst_n low after 2 of 4 pairs, then 4 pairs (5,5) -> dout=100, and dout_valid=0 throughout reset.
REQ-035 SHALL check DOT_LEN=1 with NUM_STAGE=4: pair (-7,9) -> dout=-63 five cycles after accept.
